// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator car controller.
// Floor masks let the scheduler ask "any call above/below floor f" without per-floor logic.
package elevator_pkg;

  localparam int FLOOR_W  = 2;
  localparam int N_FLOORS = 4;

  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;
  localparam logic DOOR_OPEN_V   = 1'b1;
  localparam logic DOOR_CLOSED_V = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2,
    ST_HALT      = 2'd3
  } state_t;

  function automatic logic [N_FLOORS-1:0] floors_above(input logic [FLOOR_W-1:0] floor);
    logic [N_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < N_FLOORS; i++) m[i] = (i > int'(floor));
    return m;
  endfunction

  function automatic logic [N_FLOORS-1:0] floors_below(input logic [FLOOR_W-1:0] floor);
    logic [N_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < N_FLOORS; i++) m[i] = (i < int'(floor));
    return m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV enabled cycles.
// Dropping en freezes the count in place so elapsed time resumes where it stopped.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: next-state logic assigns its default first so no path leaves count_d unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (en) count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
  end

  // NOTE: reset is sampled on the clock edge, and state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy car controller: latches floor calls, times travel and door dwell from a
// prescaled tick, and exposes floor/direction/door/stop status for the display.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                stop_btn,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic                ud_state,
  output logic                oc_state,
  output logic                stop,
  output logic [N_FLOORS-1:0] pending
);

  localparam int TMR_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TICKS - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST = TMR_W'(DOOR_TICKS - 1);

  state_t                state_q, state_d;
  state_t                resume_q, resume_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic                  door_q, door_d;
  logic [N_FLOORS-1:0]   pending_q, pending_d;
  logic [TMR_W-1:0]      timer_q, timer_d;

  logic                  tick;
  logic                  above, below, beyond;
  logic [FLOOR_W-1:0]    next_floor;
  logic [N_FLOORS-1:0]   call_set, pending_clr;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != ST_HALT),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    door_d      = door_q;
    timer_d     = timer_q;
    pending_clr = '0;
    call_set    = call_req;
    above       = |(pending_q & floors_above(floor_q));
    below       = |(pending_q & floors_below(floor_q));
    next_floor  = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    beyond      = (dir_q == DIR_UP) ? |(pending_q & floors_above(next_floor))
                                    : |(pending_q & floors_below(next_floor));

    // A same-floor call with the door open only extends the dwell; during a stop request it is kept.
    if (state_q == ST_DOOR_OPEN && !stop_btn) call_set[floor_q] = 1'b0;

    if (stop_btn && state_q != ST_HALT) begin
      state_d  = ST_HALT;
      resume_d = state_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pending_q[floor_q]) begin
            state_d              = ST_DOOR_OPEN;
            door_d               = DOOR_OPEN_V;
            timer_d              = '0;
            pending_clr[floor_q] = 1'b1;
          end else if ((dir_q == DIR_UP && above) || below || above) begin
            state_d = ST_MOVING;
            timer_d = '0;
            if (!(dir_q == DIR_UP && above)) dir_d = below ? DIR_DOWN : DIR_UP;
          end
        end
        ST_MOVING: begin
          if (tick) begin
            if (timer_q == MOVE_LAST) begin
              floor_d = next_floor;
              timer_d = '0;
              if (pending_q[next_floor]) begin
                state_d                 = ST_DOOR_OPEN;
                door_d                  = DOOR_OPEN_V;
                pending_clr[next_floor] = 1'b1;
              end else if (!beyond) begin
                state_d = ST_IDLE;
              end
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (call_req[floor_q]) begin
            timer_d = '0;
          end else if (tick) begin
            if (timer_q == DOOR_LAST) begin
              door_d  = DOOR_CLOSED_V;
              timer_d = '0;
              state_d = ST_IDLE;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (!stop_btn) state_d = resume_q;
        end
      endcase
    end

    pending_d = (pending_q | call_set) & ~pending_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      resume_q  <= ST_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      door_q    <= DOOR_CLOSED_V;
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  assign current_floor = floor_q;
  assign ud_state      = dir_q;
  assign oc_state      = door_q;
  assign pending       = pending_q;
  assign stop          = (state_q == ST_HALT) || (state_q == ST_IDLE && pending_q == '0);

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Car-motion controller for the 4-floor elevator.
- Latches floor call buttons and serves them with a SCAN policy: continue in the current direction while calls remain that way, otherwise reverse.
- Times travel between floors and door-open dwell from a prescaled tick.
- Drives the floor, direction, door and stop status into the 7-segment display controller.

Parameters:
- TICK_DIV, 50000000: clk cycles per time tick (1 s at 50 MHz); minimum 2.
- MOVE_TICKS, 2: ticks to travel one floor; minimum 1.
- DOOR_TICKS, 3: ticks the door stays open; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- call_req  in  4  per-floor call, already debounced; a bit high in any cycle latches that call.
- stop_btn  in  1  emergency stop (level).
- current_floor  out  2  floor index 0..3.
- ud_state  out  1  direction: 1 = up, 0 = down.
- oc_state  out  1  door: 1 = open, 0 = closed.
- stop  out  1  1 = car halted or idle with no work.
- pending  out  4  latched outstanding calls.

Behaviour:
- One clock domain is used, and reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values, applied on the first edge with rst_n=0, including mid-operation:
  - state IDLE, current_floor 0, ud_state 1, oc_state 0, pending 0, stop 1;
  - prescaler, phase timer and resume register all 0.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when count = TICK_DIV-1.
  - The prescaler free-runs in all states except HALT, where it freezes.
- Pending:
  - pending[i] is set on any cycle with call_req[i]=1, in every state including HALT.
  - pending[i] is cleared only on the cycle the FSM enters DOOR_OPEN at floor i.
  - If set and clear for the same floor coincide, clear wins.
  - A call for the current floor while in DOOR_OPEN is not latched; it restarts the door timer instead.
- Helpers:
  - above = |(pending bits with index > current_floor).
  - below = |(pending bits with index < current_floor).
- FSM states: IDLE, MOVING, DOOR_OPEN, HALT.
- Priority: stop_btn=1 in IDLE, MOVING or DOOR_OPEN forces HALT on the next edge. The current state is saved to the resume register, and all outputs except stop are held.
- IDLE:
  - If pending[current_floor] → DOOR_OPEN.
  - Else, if ud_state=1 and above → MOVING (up).
  - Else, if below → MOVING with ud_state set to 0.
  - Else, if above → MOVING with ud_state set to 1.
  - Else, stay in IDLE.
  - The phase timer clears on entry to MOVING.
- MOVING:
  - The phase timer increments on each tick.
  - On the tick where timer = MOVE_TICKS-1, current_floor moves ±1 by ud_state and the timer clears.
  - At the new floor: if pending[new] → DOOR_OPEN; else if calls remain beyond it in ud_state direction → stay MOVING; else → IDLE.
  - Floor never wraps: leaving floor 3 upward or floor 0 downward is unreachable. Verification must assert this.
- DOOR_OPEN:
  - On entry: oc_state=1, timer cleared, pending[current_floor] cleared.
  - After DOOR_TICKS ticks: oc_state=0 and next state IDLE. The next direction is decided in IDLE one cycle later.
- HALT:
  - stop=1; timer and prescaler frozen; current_floor, ud_state and oc_state held.
  - When stop_btn=0 → return to the saved state with timer and prescaler intact, so elapsed time continues.
- stop = (state==HALT) or (state==IDLE and pending==0).
- Outputs are direct register values, except stop, which is a combinational decode of registers.

Decomposition:
- Shared package elevator_pkg:
  - state encoding localparams;
  - FLOOR_W = 2, N_FLOORS = 4;
  - DIR_UP = 1, DIR_DOWN = 0;
  - DOOR_OPEN_V = 1, DOOR_CLOSED_V = 0.
- Sub-module tick_prescaler:
  - parameter TICK_DIV;
  - ports clk, rst_n, en, tick.
- Everything else lives in elevator_scheduler.

Test Plan (TICK_DIV=4, MOVE_TICKS=2, DOOR_TICKS=3):
1. Hold rst_n=0 for 2 edges → current_floor=0, ud_state=1, oc_state=0, pending=0000, stop=1.
2. From reset, pulse call_req=0100 → pending=0100 and stop=0. Then current_floor=1 after 8 cycles and 2 after 16, oc_state=1 and pending=0000, door open for 12 cycles, then IDLE with stop=1.
3. While moving up from floor 0 toward floor 3, pulse call_req=0001 at floor 1 → car serves floor 3 first (door opens), then ud_state=0 and car travels to floor 0.
4. At floor 2 in IDLE, pulse call_req=0100 → oc_state=1 after 2 cycles with no floor change. Re-pulse 0100 mid-dwell → door stays open a full 12 cycles from the re-pulse.
5. Assert stop_btn for 20 cycles mid-MOVING → stop=1 and current_floor frozen. On release the car resumes and arrival is delayed by exactly 20 cycles. A call_req pulsed during HALT appears in pending.
6. Drive rst_n=0 for 1 edge while MOVING at floor 2 with pending=1001 → all reset values on that edge, and the car stays idle at floor 0.
